// File: rtl/pid_hdng_ctrl_if.sv
// pid_hdng_ctrl_if
//   Bundles the heading-controller bus between the heading/gyro front end
//   (master) and the heading PID controller (slave).
//   Signal names are given from the controller's point of view:
//     i_moving     drive enabled
//     i_hdng_vld   new actual-heading sample this cycle
//     i_dsrd_hdng  desired heading, signed HDNG_W
//     i_actl_hdng  actual heading, signed HDNG_W
//     i_frwrd_spd  forward speed, unsigned SPD_W
//     o_lft_spd    left wheel speed, signed SPD_W+1
//     o_rght_spd   right wheel speed, signed SPD_W+1
//     o_at_hdng    heading error inside the at-heading window
//     o_spd_vld    one-cycle strobe: wheel speeds updated from a new sample
interface pid_hdng_ctrl_if #(
  parameter int HDNG_W = 12,
  parameter int SPD_W  = 11
);
  logic                     i_moving;
  logic                     i_hdng_vld;
  logic signed [HDNG_W-1:0] i_dsrd_hdng;
  logic signed [HDNG_W-1:0] i_actl_hdng;
  logic        [SPD_W-1:0]  i_frwrd_spd;
  logic signed [SPD_W:0]    o_lft_spd;
  logic signed [SPD_W:0]    o_rght_spd;
  logic                     o_at_hdng;
  logic                     o_spd_vld;

  modport master (
    output i_moving, i_hdng_vld, i_dsrd_hdng, i_actl_hdng, i_frwrd_spd,
    input  o_lft_spd, o_rght_spd, o_at_hdng, o_spd_vld
  );

  modport slave (
    input  i_moving, i_hdng_vld, i_dsrd_hdng, i_actl_hdng, i_frwrd_spd,
    output o_lft_spd, o_rght_spd, o_at_hdng, o_spd_vld
  );
endinterface

// File: rtl/pid_hdng_ctrl.sv
// pid_hdng_ctrl
//   Two-stage pipelined heading PID controller. Stage 1 forms the saturated
//   heading error and registers the P and D terms, the integrator and the
//   derivative history; stage 2 adds the I term, scales the sum by 1/8 and
//   mixes it into the forward speed to give left/right wheel speeds.
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   if_hdng  pid_hdng_ctrl_if.slave (moving, hdng_vld, headings, forward
//            speed in; wheel speeds, at_hdng, spd_vld out)
// Build option:
//   PID_SPD_CLIP_EN  when defined, wheel speeds are computed one bit wider
//                    and clamped to the signed SPD_W+1 range; otherwise they
//                    wrap in two's complement.
module pid_hdng_ctrl #(
  parameter int HDNG_W      = 12,
  parameter int ERR_W       = 10,
  parameter int SPD_W       = 11,
  parameter int INT_W       = 16,
  parameter int I_SHIFT     = 4,
  parameter int P_COEFF     = 3,
  parameter int D_COEFF     = 14,
  parameter int D_SAT_W     = 8,
  parameter int D_DEPTH     = 2,
  parameter int AT_HDNG_THR = 30
) (
  input  logic           clk,
  input  logic           rst_n,
  pid_hdng_ctrl_if.slave if_hdng
);

  localparam int SUM_W = SPD_W + 4;    // width the three PID terms are summed at
  localparam int P_W   = ERR_W + 5;    // signed err x 5-bit signed gain
  localparam int D_W   = D_SAT_W + 6;  // signed d_sat x 6-bit signed gain
  localparam int OUT_W = SPD_W + 1;

  localparam logic signed [HDNG_W-1:0] ERR_MAX = HDNG_W'((1 << (ERR_W - 1)) - 1);
  localparam logic signed [HDNG_W-1:0] ERR_MIN = HDNG_W'(-(1 << (ERR_W - 1)));
  localparam logic signed [ERR_W:0]    DSAT_MAX = (ERR_W + 1)'((1 << (D_SAT_W - 1)) - 1);
  localparam logic signed [ERR_W:0]    DSAT_MIN = (ERR_W + 1)'(-(1 << (D_SAT_W - 1)));
  localparam logic signed [ERR_W-1:0]  THR_POS  = ERR_W'(AT_HDNG_THR);
  localparam logic signed [ERR_W-1:0]  THR_NEG  = ERR_W'(-AT_HDNG_THR);

  // ---------------------------------------------------------------- stage 1
  logic signed [HDNG_W-1:0] w_err;
  logic signed [ERR_W-1:0]  w_err_sat;
  logic signed [ERR_W:0]    w_d_diff;
  logic signed [D_SAT_W-1:0] w_d_sat;
  logic signed [P_W-1:0]    w_p_term;
  logic signed [D_W-1:0]    w_d_term;
  logic signed [INT_W-1:0]  w_err_ext;
  logic signed [INT_W-1:0]  w_integ_sum;
  logic                     w_integ_ovf;
  logic signed [ERR_W-1:0]  w_hist_in [D_DEPTH];

  logic                     r_vld1;
  logic signed [ERR_W-1:0]  r_err_sat;
  logic signed [P_W-1:0]    r_p_term;
  logic signed [D_W-1:0]    r_d_term;
  logic signed [INT_W-1:0]  r_integ;
  logic signed [ERR_W-1:0]  r_hist [D_DEPTH];

  // Heading difference wraps at HDNG_W, then clamps into ERR_W.
  assign w_err = if_hdng.i_actl_hdng - if_hdng.i_dsrd_hdng;

  always_comb begin
    w_err_sat = w_err[ERR_W-1:0];
    if (w_err > ERR_MAX)
      w_err_sat = ERR_MAX[ERR_W-1:0];
    else if (w_err < ERR_MIN)
      w_err_sat = ERR_MIN[ERR_W-1:0];
  end

  // Derivative compares against the oldest history entry (pre-shift value).
  assign w_d_diff = (ERR_W + 1)'(w_err_sat) - (ERR_W + 1)'(r_hist[D_DEPTH-1]);

  always_comb begin
    w_d_sat = w_d_diff[D_SAT_W-1:0];
    if (w_d_diff > DSAT_MAX)
      w_d_sat = DSAT_MAX[D_SAT_W-1:0];
    else if (w_d_diff < DSAT_MIN)
      w_d_sat = DSAT_MIN[D_SAT_W-1:0];
  end

  assign w_p_term = P_W'(w_err_sat) * P_W'($signed(5'(P_COEFF)));
  assign w_d_term = D_W'(w_d_sat)   * D_W'($signed(6'(D_COEFF)));

  // Anti-windup: an add whose operands share a sign but whose result does
  // not is dropped, so the integrator parks at its last in-range value.
  assign w_err_ext   = INT_W'(w_err_sat);
  assign w_integ_sum = r_integ + w_err_ext;
  assign w_integ_ovf = (r_integ[INT_W-1] == w_err_ext[INT_W-1]) &&
                       (w_integ_sum[INT_W-1] != r_integ[INT_W-1]);

  // Shift-register taps: entry 0 takes the new error, the rest move down.
  generate
    for (genvar gi = 0; gi < D_DEPTH; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        assign w_hist_in[gi] = w_err_sat;
      end else begin : g_tail
        assign w_hist_in[gi] = r_hist[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld1    <= 1'b0;
      r_err_sat <= '0;
      r_p_term  <= '0;
      r_d_term  <= '0;
      r_integ   <= '0;
      for (int i = 0; i < D_DEPTH; i++) r_hist[i] <= '0;
    end else begin
      r_vld1 <= if_hdng.i_hdng_vld;
      if (if_hdng.i_hdng_vld) begin
        r_err_sat <= w_err_sat;
        r_p_term  <= w_p_term;
        r_d_term  <= w_d_term;
        for (int i = 0; i < D_DEPTH; i++) r_hist[i] <= w_hist_in[i];
      end
      // Not moving clears the integrator on every edge, sample or not.
      if (!if_hdng.i_moving)
        r_integ <= '0;
      else if (if_hdng.i_hdng_vld && !w_integ_ovf)
        r_integ <= w_integ_sum;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic signed [INT_W-1:0] w_i_term;
  logic signed [SUM_W-1:0] w_pid;
  logic signed [OUT_W-1:0] w_corr;
  logic signed [OUT_W-1:0] w_lft;
  logic signed [OUT_W-1:0] w_rght;
  logic                    w_at_hdng;

  // I term uses the integrator as already updated by this sample's stage 1.
  assign w_i_term = r_integ >>> I_SHIFT;
  assign w_pid    = SUM_W'(r_p_term) + SUM_W'(w_i_term) + SUM_W'(r_d_term);
  // Arithmetic shift gives floor division by 8.
  assign w_corr   = OUT_W'(w_pid >>> 3);

`ifdef PID_SPD_CLIP_EN
  localparam logic signed [OUT_W:0] SPD_MAX = (OUT_W + 1)'((1 << SPD_W) - 1);
  localparam logic signed [OUT_W:0] SPD_MIN = (OUT_W + 1)'(-(1 << SPD_W));

  logic signed [OUT_W:0] w_lft_wide;
  logic signed [OUT_W:0] w_rght_wide;

  assign w_lft_wide  = $signed({2'b00, if_hdng.i_frwrd_spd}) + (OUT_W + 1)'(w_corr);
  assign w_rght_wide = $signed({2'b00, if_hdng.i_frwrd_spd}) - (OUT_W + 1)'(w_corr);

  always_comb begin
    w_lft = w_lft_wide[OUT_W-1:0];
    if (w_lft_wide > SPD_MAX)
      w_lft = SPD_MAX[OUT_W-1:0];
    else if (w_lft_wide < SPD_MIN)
      w_lft = SPD_MIN[OUT_W-1:0];

    w_rght = w_rght_wide[OUT_W-1:0];
    if (w_rght_wide > SPD_MAX)
      w_rght = SPD_MAX[OUT_W-1:0];
    else if (w_rght_wide < SPD_MIN)
      w_rght = SPD_MIN[OUT_W-1:0];
  end
`else
  assign w_lft  = $signed({1'b0, if_hdng.i_frwrd_spd}) + w_corr;
  assign w_rght = $signed({1'b0, if_hdng.i_frwrd_spd}) - w_corr;
`endif

  assign w_at_hdng = (r_err_sat > THR_NEG) && (r_err_sat < THR_POS);

  logic signed [OUT_W-1:0] r_lft;
  logic signed [OUT_W-1:0] r_rght;
  logic                    r_at_hdng;
  logic                    r_spd_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft     <= '0;
      r_rght    <= '0;
      r_at_hdng <= 1'b0;
      r_spd_vld <= 1'b0;
    end else begin
      r_spd_vld <= r_vld1;
      if (r_vld1)
        r_at_hdng <= w_at_hdng;
      if (!if_hdng.i_moving) begin
        r_lft  <= '0;
        r_rght <= '0;
      end else if (r_vld1) begin
        r_lft  <= w_lft;
        r_rght <= w_rght;
      end
    end
  end

  assign if_hdng.o_lft_spd  = r_lft;
  assign if_hdng.o_rght_spd = r_rght;
  assign if_hdng.o_at_hdng  = r_at_hdng;
  assign if_hdng.o_spd_vld  = r_spd_vld;

endmodule

// File: tb/tb_pid_hdng_ctrl.sv
// tb_pid_hdng_ctrl
//   Self-checking bench for pid_hdng_ctrl: directed scenarios followed by
//   randomized traffic, every cycle compared against an integer reference
//   model of the controller.
module tb_pid_hdng_ctrl;

  localparam int D_DEPTH = 2;
  localparam int THR     = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pid_hdng_ctrl_if #(.HDNG_W(12), .SPD_W(11)) bus ();

  pid_hdng_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_hdng (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_txn = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  int m_integ, m_p, m_d, m_err;
  int m_hist [D_DEPTH];
  int m_vld1;
  int m_lft, m_rght, m_at, m_spd;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int fit_speed(input int v);
    int w;
`ifdef PID_SPD_CLIP_EN
    return clamp(v, -2048, 2047);
`else
    w = v & 4095;
    if (w >= 2048) w -= 4096;
    return w;
`endif
  endfunction

  task automatic model_reset();
    m_integ = 0; m_p = 0; m_d = 0; m_err = 0; m_vld1 = 0;
    for (int i = 0; i < D_DEPTH; i++) m_hist[i] = 0;
    m_lft = 0; m_rght = 0; m_at = 0; m_spd = 0;
  endtask

  // One clock edge of behaviour: outputs from the previous sample first,
  // then absorb this edge's input sample.
  task automatic model_step();
    int e, esat, dsat, pid, corr, frwrd, sum;
    if (!rst_n) begin
      model_reset();
      return;
    end
    frwrd = int'(bus.i_frwrd_spd);
    m_spd = m_vld1;
    if (m_vld1 != 0) m_at = (m_err > -THR && m_err < THR) ? 1 : 0;
    if (!bus.i_moving) begin
      m_lft = 0; m_rght = 0;
    end else if (m_vld1 != 0) begin
      pid    = m_p + (m_integ >>> 4) + m_d;
      corr   = pid >>> 3;
      m_lft  = fit_speed(frwrd + corr);
      m_rght = fit_speed(frwrd - corr);
    end
    esat = 0;
    if (bus.i_hdng_vld) begin
      e = int'(bus.i_actl_hdng) - int'(bus.i_dsrd_hdng);
      if (e > 2047) e -= 4096;
      if (e < -2048) e += 4096;
      esat = clamp(e, -512, 511);
      dsat = clamp(esat - m_hist[D_DEPTH-1], -128, 127);
      for (int i = D_DEPTH - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = esat;
      m_p = 3 * esat;
      m_d = 14 * dsat;
      m_err = esat;
    end
    if (!bus.i_moving) m_integ = 0;
    else if (bus.i_hdng_vld) begin
      sum = m_integ + esat;
      if (sum >= -32768 && sum <= 32767) m_integ = sum;
    end
    m_vld1 = bus.i_hdng_vld ? 1 : 0;
  endtask

  // Advance one clock, then compare every output with the model.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_val("spd_vld",  int'(bus.o_spd_vld),  m_spd);
    check_val("lft_spd",  int'(bus.o_lft_spd),  m_lft);
    check_val("rght_spd", int'(bus.o_rght_spd), m_rght);
    check_val("at_hdng",  int'(bus.o_at_hdng),  m_at);
    if (bus.o_spd_vld) begin
      n_txn++;
      $display("txn %0d: lft=%0d rght=%0d at_hdng=%0d", n_txn,
               int'(bus.o_lft_spd), int'(bus.o_rght_spd), int'(bus.o_at_hdng));
    end
  endtask

  task automatic drive(input int mv, input int vld, input int dsrd, input int actl, input int frwrd);
    bus.i_moving    = (mv != 0);
    bus.i_hdng_vld  = (vld != 0);
    bus.i_dsrd_hdng = 12'(dsrd);
    bus.i_actl_hdng = 12'(actl);
    bus.i_frwrd_spd = 11'(frwrd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // One sample followed by an idle cycle; returns after the output edge.
  task automatic one_sample(input int dsrd, input int actl, input int frwrd);
    drive(1, 1, dsrd, actl, frwrd);
    cyc();
    bus.i_hdng_vld = 1'b0;
    cyc();
  endtask

  int thr_err [4] = '{29, 30, -29, -30};
  int thr_exp [4] = '{1, 0, 1, 0};

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    cyc();
    check_val("reset_lft", int'(bus.o_lft_spd), 0);
    check_val("reset_rght", int'(bus.o_rght_spd), 0);
    check_val("reset_spd_vld", int'(bus.o_spd_vld), 0);
    check_val("reset_integ", int'(dut.r_integ), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic sample: P=600, I=12, D=1778 -> corr=298.
    one_sample(0, 200, 512);
    check_val("basic_spd_vld", int'(bus.o_spd_vld), 1);
    check_val("basic_lft", int'(bus.o_lft_spd), 810);
    check_val("basic_rght", int'(bus.o_rght_spd), 214);
    check_val("basic_at_hdng", int'(bus.o_at_hdng), 0);
    cyc();
    check_val("basic_vld_drop", int'(bus.o_spd_vld), 0);
    check_val("basic_lft_hold", int'(bus.o_lft_spd), 810);

    // Error saturation in both directions.
    drive(1, 1, 0, 1024, 512);
    cyc();
    check_val("err_sat_pos", int'(dut.r_err_sat), 511);
    drive(1, 1, 0, -1024, 512);
    cyc();
    check_val("err_sat_neg", int'(dut.r_err_sat), -512);
    check_val("err_sat_pos_at", int'(bus.o_at_hdng), 0);
    bus.i_hdng_vld = 1'b0;
    cyc();
    check_val("err_sat_neg_at", int'(bus.o_at_hdng), 0);

    // At-heading window edges.
    for (int k = 0; k < 4; k++) begin
      one_sample(0, thr_err[k], 300);
      check_val("at_hdng_thr", int'(bus.o_at_hdng), thr_exp[k]);
    end

    // Integrator saturation from zero with sustained maximum error.
    drive(0, 0, 0, 0, 300);
    cyc();
    drive(1, 1, 0, 511, 300);
    for (int k = 0; k < 70; k++) cyc();
    check_val("integ_sat", int'(dut.r_integ), 32704);
    check_val("integ_model", int'(dut.r_integ), m_integ);
    drive(0, 0, 0, 511, 300);
    cyc();
    check_val("stop_integ", int'(dut.r_integ), 0);
    check_val("stop_lft", int'(bus.o_lft_spd), 0);
    check_val("stop_rght", int'(bus.o_rght_spd), 0);

    // Speed overflow at full forward speed.
    do_reset();
    one_sample(0, 511, 2047);
`ifdef PID_SPD_CLIP_EN
    check_val("clip_lft", int'(bus.o_lft_spd), 2047);
`else
    check_val("wrap_lft", int'(bus.o_lft_spd), -1632);
`endif
    check_val("clip_rght", int'(bus.o_rght_spd), 1630);

    // Reset lands one cycle after a sample: nothing may emerge.
    drive(1, 1, 0, 100, 700);
    cyc();
    bus.i_hdng_vld = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_mid_lft", int'(bus.o_lft_spd), 0);
    check_val("rst_mid_rght", int'(bus.o_rght_spd), 0);
    check_val("rst_mid_at", int'(bus.o_at_hdng), 0);
    check_val("rst_mid_vld", int'(bus.o_spd_vld), 0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_val("rst_mid_no_pulse", int'(bus.o_spd_vld), 0);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      int dsrd, actl;
      dsrd = int'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) == 0)
        actl = dsrd + int'($urandom_range(0, 80)) - 40;
      else
        actl = int'($urandom_range(0, 4095));
      drive(($urandom_range(0, 15) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
            dsrd, actl, int'($urandom_range(0, 2047)));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pid_hdng_ctrl.md
# pid_hdng_ctrl

Parametrised, pipelined heading PID controller for the drive path. It takes desired and actual heading, forms a saturated error, and runs P, I and D terms with anti-windup and a configurable derivative lag. It mixes the PID correction into the forward speed to produce registered left/right wheel speeds with a valid strobe. It sits between the heading/gyro front end and the motor-drive block.

## Interface
- HDNG_W, 12: heading input width (signed).
- ERR_W, 10: saturated error width (signed).
- SPD_W, 11: forward speed width (unsigned); wheel speeds are SPD_W+1 signed.
- INT_W, 16: integrator width (signed).
- I_SHIFT, 4: integrator right-shift forming the I term.
- P_COEFF, 3: P gain (unsigned, ≤ 4 bits).
- D_COEFF, 14: D gain (unsigned, ≤ 5 bits).
- D_SAT_W, 8: saturated derivative difference width (signed).
- D_DEPTH, 2: derivative lag in valid samples (≥1).
- AT_HDNG_THR, 30: at-heading error threshold.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- moving  in  1  drive enabled; low clears integrator, zeroes speeds.
- hdng_vld  in  1  new actl_hdng sample this cycle.
- dsrd_hdng  in  HDNG_W  desired heading, signed.
- actl_hdng  in  HDNG_W  actual heading, signed.
- frwrd_spd  in  SPD_W  forward speed, unsigned.
- lft_spd  out  SPD_W+1  left wheel speed, signed, registered.
- rght_spd  out  SPD_W+1  right wheel speed, signed, registered.
- at_hdng  out  1  |err_sat| < AT_HDNG_THR, registered.
- spd_vld  out  1  one-cycle pulse: outputs updated from a new sample.

## Operation
- err = actl_hdng − dsrd_hdng (HDNG_W, wraps). err_sat = err clamped to signed ERR_W range [−2^(ERR_W−1), 2^(ERR_W−1)−1].
- Stage 1 (edge where hdng_vld=1): register err_sat, P term = P_COEFF·err_sat, D term, and update integrator and history.
  - Integrator: nxt = integ + sext(err_sat); load only if moving=1 and no signed overflow (operand signs equal, result sign differs) — otherwise hold. Any edge with moving=0 loads 0, regardless of hdng_vld.
  - History: D_DEPTH-entry shift register of err_sat, shifts on hdng_vld only (independent of moving). d_diff = err_sat − hist[D_DEPTH−1] (ERR_W+1 bits), clamped to signed D_SAT_W; D term = D_COEFF·d_sat.
  - valid1 <= hdng_vld.
- Stage 2 (edge where valid1=1): I term = integ >>> I_SHIFT (uses post-update integrator). PID = P + I + D, each sign-extended to SPD_W+4 bits. corr = PID[SPD_W+3:3] (arithmetic ÷8, floor). lft = frwrd_spd + corr, rght = frwrd_spd − corr. at_hdng <= (−AT_HDNG_THR < err_sat_r < AT_HDNG_THR). spd_vld <= 1.
- Output register: edge with moving=0 loads lft/rght = 0 (at_hdng still updates on valid1); moving=1 and valid1=1 loads computed speeds; else holds.
- Reset: integrator, history, pipeline registers, lft_spd, rght_spd, at_hdng, spd_vld all 0.

## Timing
- Latency 2 edges: hdng_vld sampled at edge N → outputs and spd_vld=1 after edge N+1; spd_vld=0 after N+2 unless another sample.
- Back-to-back hdng_vld every cycle supported; one output per sample, in order.
- moving falls: integrator 0 and speeds 0 after the next edge; moving rises: integration restarts from 0 on the next sample.
- rst_n asserted mid-pipeline: in-flight sample discarded, all outputs 0 immediately (asynchronous).

## Configuration
- PID_SPD_CLIP_EN defined: lft/rght computed at SPD_W+2 bits and clamped to signed SPD_W+1 range [−2^SPD_W, 2^SPD_W−1].
- Undefined: lft/rght computed at SPD_W+1 bits, two's-complement wrap.

## Test plan
- Defaults, reset, moving=1, frwrd=512, dsrd=0, actl=200, one hdng_vld → two edges later spd_vld pulse, P=600, I=12, D=14·127=1778, corr=298, lft=810, rght=214, at_hdng=0.
- actl=1024, dsrd=0 → err_sat=511 (and actl=−1024 → −512); at_hdng=0.
- Steady err 29 / 30 / −29 / −30 → at_hdng 1 / 0 / 1 / 0.
- moving=1, sustained err=511 until integrator saturates → integrator holds at last non-overflowing value (no sign flip); drop moving → integrator 0, lft=rght=0 next edge.
- frwrd=2047, err=511 first sample (corr=417): with PID_SPD_CLIP_EN lft=2047; without lft=−1632; rght=1630 both.
- rst_n low one cycle after hdng_vld → spd_vld never pulses, all outputs 0.
